// File: rtl/popcount_pipe_if.sv
// rtl/popcount_pipe_if.sv - input/output stream handshake bundle for popcount_pipe
interface popcount_pipe_if #(
  parameter int N = 32,
  parameter int W = $clog2(N + 1)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );
endinterface

// File: rtl/popcount_pipe.sv
// rtl/popcount_pipe.sv - pipelined 3:2 carry-save popcount with valid/ready handshake
// Optional running-total accumulator is built when POPCNT_ACCUM_EN is defined.
module popcount_pipe #(
  parameter int N     = 32,
  parameter int PIPE  = 2,
  parameter int ACC_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  popcount_pipe_if.slave pc
`ifdef POPCNT_ACCUM_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
`endif
);
  localparam int W = $clog2(N + 1);

  typedef logic [W-1:0][N-1:0] cols_t;  // [weight][slot], live bits packed at low slots
  typedef logic [W-1:0][15:0]  hts_t;

  function automatic hts_t heights(int lvl);
    hts_t h;
    hts_t nh;
    h    = '0;
    h[0] = 16'(N);
    for (int l = 0; l < lvl; l++) begin
      nh    = '0;
      nh[0] = h[0] / 16'd3 + h[0] % 16'd3;
      for (int i = 1; i < W; i++) nh[i] = h[i] / 16'd3 + h[i] % 16'd3 + h[i-1] / 16'd3;
      h = nh;
    end
    return h;
  endfunction

  function automatic int count_levels();
    int   lv;
    hts_t h;
    logic tall;
    lv = 0;
    for (int l = 0; l < 64; l++) begin
      h    = heights(l);
      tall = 1'b0;
      for (int i = 0; i < W; i++) if (h[i] > 16'd2) tall = 1'b1;
      if (lv == l && tall) lv = l + 1;
    end
    return lv;
  endfunction

  localparam int L = count_levels();
  localparam int D = L + 1;

  // Per weight: group sums first, then the 1-2 leftover bits, then carries from the weight below.
  function automatic cols_t csa_level(cols_t c, int lvl);
    cols_t r;
    hts_t  h;
    int    ng;
    int    base;
    r = '0;
    h = heights(lvl);
    for (int w = 0; w < W; w++) begin
      ng = int'(h[w]) / 3;
      for (int g = 0; g < ng; g++) r[w][g] = c[w][3*g] ^ c[w][3*g+1] ^ c[w][3*g+2];
      for (int j = 0; j < int'(h[w]) % 3; j++) r[w][ng+j] = c[w][3*ng+j];
    end
    for (int w = 1; w < W; w++) begin
      base = int'(h[w]) / 3 + int'(h[w]) % 3;
      ng   = int'(h[w-1]) / 3;
      for (int g = 0; g < ng; g++)
        r[w][base+g] = (c[w-1][3*g] & c[w-1][3*g+1]) |
                       (c[w-1][3*g+2] & (c[w-1][3*g] ^ c[w-1][3*g+1]));
    end
    return r;
  endfunction

  function automatic cols_t final_add(cols_t c);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    cols_t        r;
    for (int w = 0; w < W; w++) begin
      a[w] = c[w][0];
      b[w] = c[w][1];
    end
    s = a + b;
    r = '0;
    for (int w = 0; w < W; w++) r[w][0] = s[w];
    return r;
  endfunction

  function automatic logic [W-1:0] low_slots(cols_t c);
    logic [W-1:0] v;
    for (int w = 0; w < W; w++) v[w] = c[w][0];
    return v;
  endfunction

  logic  adv;
  cols_t in_cols;

  assign in_cols = {{((W - 1) * N){1'b0}}, pc.in_data};

  // Steps 0..L-1 are compressor levels, step L is the final adder; segments split them evenly.
  for (genvar g = 0; g < PIPE; g++) begin : g_stage
    localparam int S0 = g * D / PIPE;
    localparam int S1 = (g + 1) * D / PIPE;
    cols_t seg_in;
    cols_t data_d;
    cols_t data_q;
    logic  vld_in;
    logic  vld_q;

    if (g == 0) begin : g_head
      assign seg_in = in_cols;
      assign vld_in = pc.in_valid;
    end else begin : g_body
      assign seg_in = g_stage[g-1].data_q;
      assign vld_in = g_stage[g-1].vld_q;
    end

    always_comb begin
      data_d = seg_in;
      for (int k = S0; k < S1; k++) begin
        if (k < L) data_d = csa_level(data_d, k);
        else       data_d = final_add(data_d);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        if (g == PIPE - 1) data_q <= '0;
      end else if (adv) begin
        vld_q  <= vld_in;
        data_q <= data_d;
      end
    end
  end

  assign adv          = !g_stage[PIPE-1].vld_q | pc.out_ready;
  assign pc.in_ready  = adv;
  assign pc.out_valid = g_stage[PIPE-1].vld_q;
  assign pc.out_count = low_slots(g_stage[PIPE-1].data_q);

`ifdef POPCNT_ACCUM_EN
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
    acc_d = acc_clr ? '0 : acc_q;
    if (pc.out_valid && pc.out_ready) acc_d = acc_d + ACC_W'(pc.out_count);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
`endif
endmodule

// File: tb/tb_popcount_pipe.sv
// tb/tb_popcount_pipe.sv - directed and randomized checks of popcount_pipe against $countones
module tb_popcount_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int q7[$];
  int q32[$];
  int q64[$];
  logic        live;
  logic [63:0] e;

  popcount_pipe_if #(.N(32)) m ();
  popcount_pipe_if #(.N(7))  a ();
  popcount_pipe_if #(.N(32)) b ();
  popcount_pipe_if #(.N(64)) c ();

`ifdef POPCNT_ACCUM_EN
  logic        acc_clr;
  logic [7:0]  acc_m;
  logic [15:0] acc_a;
  logic [15:0] acc_b;
  logic [15:0] acc_c;
`endif

  popcount_pipe #(.N(32), .PIPE(2), .ACC_W(8)) u_main (
    .clk(clk), .rst(rst), .pc(m)
`ifdef POPCNT_ACCUM_EN
    , .acc_clr(acc_clr), .acc(acc_m)
`endif
  );
  popcount_pipe #(.N(7), .PIPE(4)) u_r7 (
    .clk(clk), .rst(rst), .pc(a)
`ifdef POPCNT_ACCUM_EN
    , .acc_clr(1'b0), .acc(acc_a)
`endif
  );
  popcount_pipe #(.N(32), .PIPE(1)) u_r32 (
    .clk(clk), .rst(rst), .pc(b)
`ifdef POPCNT_ACCUM_EN
    , .acc_clr(1'b0), .acc(acc_b)
`endif
  );
  popcount_pipe #(.N(64), .PIPE(4)) u_r64 (
    .clk(clk), .rst(rst), .pc(c)
`ifdef POPCNT_ACCUM_EN
    , .acc_clr(1'b0), .acc(acc_c)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m.in_valid = 1'b1; m.in_data = $urandom; m.out_ready = 1'b1;
    a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
    c.in_valid = 1'b0; c.in_data = '0; c.out_ready = 1'b1;
`ifdef POPCNT_ACCUM_EN
    acc_clr = 1'b0;
`endif

    // reset held three cycles with in_valid asserted
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_out_valid", m.out_valid, 0);
      chk("rst_out_count", m.out_count, 0);
      m.in_data = $urandom;
    end
    rst = 1'b0;
    m.in_valid = 1'b0;
    #1 chk("rst_in_ready", m.in_ready, 1);

    // corner words back-to-back
    @(negedge clk); m.in_valid = 1'b1; m.in_data = 32'h0000_0000; #1 chk("c_lat0", m.out_valid, 0);
    @(negedge clk); m.in_data = 32'hFFFF_FFFF; #1 chk("c_lat1", m.out_valid, 0);
    @(negedge clk); m.in_data = 32'h8000_0001; #1 chk("c0_v", m.out_valid, 1); chk("c0_cnt", m.out_count, 0);
    @(negedge clk); m.in_data = 32'hAAAA_5555; #1 chk("c1_v", m.out_valid, 1); chk("c1_cnt", m.out_count, 32);
    @(negedge clk); m.in_valid = 1'b0; #1 chk("c2_v", m.out_valid, 1); chk("c2_cnt", m.out_count, 2);
    @(negedge clk); #1 chk("c3_v", m.out_valid, 1); chk("c3_cnt", m.out_count, 16);
    @(negedge clk); #1 chk("c_end", m.out_valid, 0);

    // stall with 0xFF at the output
    @(negedge clk); m.in_valid = 1'b1; m.in_data = 32'h0000_00FF; m.out_ready = 1'b1;
    @(negedge clk); m.in_data = 32'h0000_000F; m.out_ready = 1'b0;
    #1 chk("s_pre_v", m.out_valid, 0); chk("s_pre_rdy", m.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); m.in_data = 32'h0000_0003; #1;
      chk("s_hold_v", m.out_valid, 1);
      chk("s_hold_cnt", m.out_count, 8);
      chk("s_hold_rdy", m.in_ready, 0);
    end
    @(negedge clk); m.out_ready = 1'b1; #1 chk("s_rel_cnt", m.out_count, 8); chk("s_rel_rdy", m.in_ready, 1);
    @(negedge clk); m.in_valid = 1'b0; #1 chk("s_ord1_v", m.out_valid, 1); chk("s_ord1_cnt", m.out_count, 4);
    @(negedge clk); #1 chk("s_ord2_v", m.out_valid, 1); chk("s_ord2_cnt", m.out_count, 2);
    @(negedge clk); #1 chk("s_end", m.out_valid, 0);

    // reset with two words in flight
    @(negedge clk); m.in_valid = 1'b1; m.in_data = $urandom;
    @(negedge clk); m.in_data = $urandom;
    @(negedge clk); m.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1 chk("mr_v0", m.out_valid, 0); chk("mr_cnt", m.out_count, 0);
    @(negedge clk); #1 chk("mr_v1", m.out_valid, 0);
    @(negedge clk); #1 chk("mr_v2", m.out_valid, 0);

    // N=7 all ones through the 4-stage instance
    @(negedge clk); a.in_valid = 1'b1; a.in_data = 7'h7F;
    @(negedge clk); a.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1 chk("n7_lat", a.out_valid, 0);
    @(negedge clk); #1 chk("n7_v", a.out_valid, 1); chk("n7_cnt", a.out_count, 7);
    @(negedge clk); #1 chk("n7_end", a.out_valid, 0);

    // random traffic on three configurations, then drain
    for (int cyc = 0; cyc < 6020; cyc++) begin
      @(negedge clk);
      live = (cyc < 6000);
      a.in_valid = live && ($urandom_range(0, 3) != 0);
      a.in_data  = 7'($urandom);
      a.out_ready = !live || ($urandom_range(0, 3) != 0);
      b.in_valid = live && ($urandom_range(0, 3) != 0);
      b.in_data  = $urandom;
      b.out_ready = !live || ($urandom_range(0, 3) != 0);
      c.in_valid = live && ($urandom_range(0, 3) != 0);
      c.in_data  = {$urandom, $urandom};
      c.out_ready = !live || ($urandom_range(0, 3) != 0);
      #1;
      if (a.out_valid && a.out_ready) begin
        e = (q7.size() > 0) ? 64'(q7.pop_front()) : 64'hDEAD;
        chk("r7_cnt", a.out_count, e);
      end
      if (a.in_valid && a.in_ready) q7.push_back($countones(a.in_data));
      if (b.out_valid && b.out_ready) begin
        e = (q32.size() > 0) ? 64'(q32.pop_front()) : 64'hDEAD;
        chk("r32_cnt", b.out_count, e);
      end
      if (b.in_valid && b.in_ready) q32.push_back($countones(b.in_data));
      if (c.out_valid && c.out_ready) begin
        e = (q64.size() > 0) ? 64'(q64.pop_front()) : 64'hDEAD;
        chk("r64_cnt", c.out_count, e);
      end
      if (c.in_valid && c.in_ready) q64.push_back($countones(c.in_data));
    end
    chk("r7_drain", q7.size(), 0);
    chk("r32_drain", q32.size(), 0);
    chk("r64_drain", q64.size(), 0);

`ifdef POPCNT_ACCUM_EN
    @(negedge clk); m.in_valid = 1'b0; m.out_ready = 1'b1; acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0; #1 chk("acc_clr", acc_m, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); m.in_valid = 1'b1; m.in_data = 32'hFFFF_FFFF;
    end
    @(negedge clk); m.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("acc_wrap", acc_m, 32);
    @(negedge clk); m.in_valid = 1'b1; m.in_data = 32'h0000_001F;
    @(negedge clk); m.in_valid = 1'b0;
    @(negedge clk); #1 chk("acc_v", m.out_valid, 1); chk("acc_cnt", m.out_count, 5); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0; #1 chk("acc_clr_add", acc_m, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
